// File: rtl/data_sram_bridge.sv
// Bridges the core's SRAM-style data port onto a split addr_ok/data_ok bus; stalls the core
// while a request is outstanding (3 stall cycles on a zero-wait bus). Optional posted write buffer: DATA_BRIDGE_WBUF_EN.
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sram_en,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int SW = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        fin_state;
  logic [SW-1:0]     wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              in_req;
  logic              is_rd;
  logic              capture;
  logic              resp_fire;
  logic [1:0]        size_enc;

  assign in_req    = (state == S_REQ);
  assign is_rd     = (wen_q == '0);
  assign capture   = (state == S_IDLE) && data_sram_en;
  assign resp_fire = (in_req && bus_addr_ok && bus_data_ok) ||
                     ((state == S_WAIT) && bus_data_ok);

`ifdef DATA_BRIDGE_WBUF_EN
  // posted_q marks the in-flight transaction as a buffered store the core no longer waits on
  logic posted_q;

  assign fin_state = posted_q ? S_IDLE : S_DONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      posted_q <= 1'b0;
    end else if (capture) begin
      posted_q <= (data_sram_wen != '0);
    end else if (resp_fire) begin
      posted_q <= 1'b0;
    end
  end

  always_comb begin
    stallreq = 1'b0;
    case (state)
      S_IDLE:         stallreq = data_sram_en && (data_sram_wen == '0);
      S_REQ, S_WAIT:  stallreq = posted_q ? data_sram_en : 1'b1;
      default:        stallreq = 1'b0;
    endcase
  end
`else
  assign fin_state = S_DONE;
  assign stallreq  = capture || (state == S_REQ) || (state == S_WAIT);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (data_sram_en) state_nxt = S_REQ;
      S_REQ:  if (bus_addr_ok)  state_nxt = bus_data_ok ? fin_state : S_WAIT;
      S_WAIT: if (bus_data_ok)  state_nxt = fin_state;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        wen_q   <= data_sram_wen;
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
      end
      if (resp_fire && is_rd) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // Irregular strobe patterns fall back to a word-sized access with the strobes untouched
  always_comb begin
    case (wen_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_enc = 2'd0;
      4'b0011, 4'b1100:                   size_enc = 2'd1;
      default:                            size_enc = 2'd2;
    endcase
  end

  assign bus_req         = in_req;
  assign bus_wr          = in_req && !is_rd;
  assign bus_size        = in_req ? size_enc : 2'd0;
  assign bus_wstrb       = in_req ? wen_q : '0;
  assign bus_addr        = !in_req ? '0 : (is_rd ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q);
  assign bus_wdata       = in_req ? wdata_q : '0;
  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Table-driven and randomized checks of data_sram_bridge against a transaction-level model.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .bus_req         (bus_req),
    .bus_wr          (bus_wr),
    .bus_size        (bus_size),
    .bus_wstrb       (bus_wstrb),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_addr_ok     (bus_addr_ok),
    .bus_data_ok     (bus_data_ok),
    .bus_rdata       (bus_rdata)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          ad;
    int          dd;
    bit          same;
    bit          hold;
    logic [1:0]  e_size;
    logic        e_wr;
    logic [3:0]  e_strb;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        tbl[8];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_size(input logic [3:0] wen);
    if (wen == 4'b0000)               return 2'd2;
    if ($countones(wen) == 1)         return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_req"},   {31'd0, bus_req}, 32'd0);
    chk({tag, "_bus_wr"},    {31'd0, bus_wr}, 32'd0);
    chk({tag, "_bus_size"},  {30'd0, bus_size}, 32'd0);
    chk({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    chk({tag, "_bus_addr"},  bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_rdata"},     data_sram_rdata, 32'd0);
    chk({tag, "_stallreq"},  {31'd0, stallreq}, 32'd0);
  endtask

  // One core access from its IDLE capture cycle through DONE; leaves en high afterwards.
  task automatic do_access(input vec_t v, input bit noisy);
    int stalls = 0;
    int exp_stalls;
    exp_stalls = 1 + (v.ad + 1) + (v.same ? 0 : v.dd + 1);
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = v.wen; data_sram_addr = v.addr; data_sram_wdata = v.wdata;
    bus_addr_ok = 1'b0; bus_data_ok = noisy ? 1'($urandom_range(0, 1)) : 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", {31'd0, stallreq}, 32'd1);
    chk("idle_no_req", {31'd0, bus_req}, 32'd0);
    if (stallreq) stalls++;
    for (int i = 0; i <= v.ad; i++) begin
      @(posedge clk); #1;
      bus_addr_ok = (i == v.ad);
      bus_data_ok = (i == v.ad) ? v.same : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      bus_rdata   = (i == v.ad && v.same) ? v.rd : $urandom;
      @(negedge clk);
      chk("req_valid", {31'd0, bus_req}, 32'd1);
      chk("req_wr",    {31'd0, bus_wr}, {31'd0, v.e_wr});
      chk("req_size",  {30'd0, bus_size}, {30'd0, v.e_size});
      chk("req_wstrb", {28'd0, bus_wstrb}, {28'd0, v.e_strb});
      chk("req_addr",  bus_addr, v.e_addr);
      if (v.e_wr) chk("req_wdata", bus_wdata, v.wdata);
      if (stallreq) stalls++;
    end
    if (!v.same) begin
      for (int i = 0; i <= v.dd; i++) begin
        @(posedge clk); #1;
        bus_addr_ok = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_data_ok = (i == v.dd);
        bus_rdata   = (i == v.dd) ? v.rd : $urandom;
        @(negedge clk);
        chk("wait_no_req", {31'd0, bus_req}, 32'd0);
        if (stallreq) stalls++;
      end
    end
    @(posedge clk); #1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", {31'd0, stallreq}, 32'd0);
    chk("done_no_req", {31'd0, bus_req}, 32'd0);
    chk("done_rdata", data_sram_rdata, v.e_rdata);
    if (stallreq) stalls++;
    chk("stall_cycles", stalls, exp_stalls);
  endtask

  task automatic idle_cycle(input bit noisy);
    @(posedge clk); #1;
    data_sram_en = 1'b0; data_sram_wen = $urandom; data_sram_addr = $urandom;
    bus_addr_ok = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_data_ok = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_rdata   = $urandom;
    @(negedge clk);
    chk("idle_quiet_stall", {31'd0, stallreq}, 32'd0);
    chk("idle_quiet_req", {31'd0, bus_req}, 32'd0);
    chk("idle_rdata_held", data_sram_rdata, model_rdata);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{wen:4'b0000, addr:32'h1000_0006, wdata:32'h0, rd:32'hDEAD_BEEF, ad:0, dd:0, same:0, hold:1,
               e_size:2'd2, e_wr:1'b0, e_strb:4'b0000, e_addr:32'h1000_0004, e_rdata:32'hDEAD_BEEF};
    tbl[1] = '{wen:4'b0100, addr:32'h2000_0002, wdata:32'h00AB_0000, rd:32'h5555_5555, ad:0, dd:0, same:0, hold:0,
               e_size:2'd0, e_wr:1'b1, e_strb:4'b0100, e_addr:32'h2000_0002, e_rdata:32'hDEAD_BEEF};
    tbl[2] = '{wen:4'b0000, addr:32'h3000_000B, wdata:32'h0, rd:32'hCAFE_F00D, ad:3, dd:2, same:0, hold:0,
               e_size:2'd2, e_wr:1'b0, e_strb:4'b0000, e_addr:32'h3000_0008, e_rdata:32'hCAFE_F00D};
    tbl[3] = '{wen:4'b0000, addr:32'h4000_000F, wdata:32'h0, rd:32'h1234_5678, ad:1, dd:0, same:1, hold:1,
               e_size:2'd2, e_wr:1'b0, e_strb:4'b0000, e_addr:32'h4000_000C, e_rdata:32'h1234_5678};
    tbl[4] = '{wen:4'b1100, addr:32'h5000_0002, wdata:32'hBEEF_0000, rd:32'hAAAA_AAAA, ad:0, dd:1, same:0, hold:1,
               e_size:2'd1, e_wr:1'b1, e_strb:4'b1100, e_addr:32'h5000_0002, e_rdata:32'h1234_5678};
    tbl[5] = '{wen:4'b1111, addr:32'h5000_0010, wdata:32'h0102_0304, rd:32'hAAAA_AAAA, ad:2, dd:0, same:0, hold:0,
               e_size:2'd2, e_wr:1'b1, e_strb:4'b1111, e_addr:32'h5000_0010, e_rdata:32'h1234_5678};
    tbl[6] = '{wen:4'b0101, addr:32'h6000_0001, wdata:32'h00CC_00DD, rd:32'hAAAA_AAAA, ad:0, dd:0, same:1, hold:0,
               e_size:2'd2, e_wr:1'b1, e_strb:4'b0101, e_addr:32'h6000_0001, e_rdata:32'h1234_5678};
    tbl[7] = '{wen:4'b0011, addr:32'h6000_0020, wdata:32'h0000_7788, rd:32'hAAAA_AAAA, ad:1, dd:1, same:0, hold:0,
               e_size:2'd1, e_wr:1'b1, e_strb:4'b0011, e_addr:32'h6000_0020, e_rdata:32'h1234_5678};

    rst = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle(1'b0);

    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i], 1'b0);
      if (tbl[i].wen == 4'b0000) model_rdata = tbl[i].rd;
      if (!tbl[i].hold) idle_cycle(1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      v.wen   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rd    = $urandom;
      v.ad    = int'($urandom_range(0, 3));
      v.dd    = int'($urandom_range(0, 3));
      v.same  = ($urandom_range(0, 3) == 0);
      v.hold  = ($urandom_range(0, 1) == 1);
      v.e_size = ref_size(v.wen);
      v.e_wr   = (v.wen != 4'b0000);
      v.e_strb = v.wen;
      v.e_addr = (v.wen == 4'b0000) ? (v.addr & 32'hFFFF_FFFC) : v.addr;
      v.e_rdata = (v.wen == 4'b0000) ? v.rd : model_rdata;
      do_access(v, 1'b1);
      model_rdata = v.e_rdata;
      if (!v.hold) idle_cycle(1'b1);
    end
    idle_cycle(1'b0);

    // Reset while waiting for data_ok, then a stray response from the abandoned read.
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h7000_0000;
    @(negedge clk);
    @(posedge clk); #1;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("rst_seq_req", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    @(negedge clk);
    chk("rst_seq_wait_stall", {31'd0, stallreq}, 32'd1);
    #1;
    rst = 1'b0; data_sram_en = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_rdata", data_sram_rdata, 32'h0);
    chk("stray_stall", {31'd0, stallreq}, 32'd0);
    chk("stray_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_rdata_after", data_sram_rdata, 32'h0);
    v = '{wen:4'b0000, addr:32'h7000_0042, wdata:32'h0, rd:32'h0F0F_A5A5, ad:0, dd:0, same:0, hold:0,
          e_size:2'd2, e_wr:1'b0, e_strb:4'b0000, e_addr:32'h7000_0040, e_rdata:32'h0F0F_A5A5};
    do_access(v, 1'b0);
    model_rdata = v.rd;
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's data-memory port, between EX/MEM and the system memory bus.
- Converts the core's fixed-latency SRAM-style data port (en/wen/addr/wdata, rdata one cycle later) into a split request/response bus with addr_ok/data_ok handshakes.
- Raises a stall request to the pipeline controller while a transaction is outstanding.
- Holds the returned read data stable until the pipeline accepts it.

Parameters:
- ADDR_W, 32, address width of core and bus ports.
- DATA_W, 32, data width; only 32 is supported (wen/wstrb are DATA_W/8 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  core access request (held high by the core while stalled).
- data_sram_wen  in  4  byte write enables; 0000 = read.
- data_sram_addr  in  ADDR_W  byte address.
- data_sram_wdata  in  DATA_W  store data, pre-aligned by the core.
- data_sram_rdata  out  DATA_W  load data returned to MEM stage.
- stallreq  out  1  pipeline stall request to controller.
- bus_req  out  1  bus request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_wstrb  out  4  byte strobes.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  request accepted this cycle (valid only when bus_req=1).
- bus_data_ok  in  1  response/write-complete this cycle.
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok.

Behaviour:
- Reset (rst=0, async): state=IDLE; bus_req=0, bus_wr=0, bus_size=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, data_sram_rdata=0, stallreq=0; request registers cleared.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If data_sram_en=1: capture wen/addr/wdata into registers, go to REQ.
  - stallreq=1 combinationally in this capture cycle.
- REQ:
  - bus_req=1, driven from the captured registers.
  - On bus_addr_ok=1, go to WAIT.
  - If bus_addr_ok and bus_data_ok are both 1 in the same cycle, go straight to DONE and latch bus_rdata.
- WAIT:
  - bus_req=0.
  - On bus_data_ok=1: latch bus_rdata into the data_sram_rdata register (reads only; writes leave it unchanged), go to DONE.
- DONE:
  - stallreq=0 for exactly one cycle; the pipeline advances; data_sram_rdata holds the latched value.
  - data_sram_en is ignored in DONE, since it is the still-held completed request.
  - Always return to IDLE next cycle.
- stallreq=1 in REQ and WAIT, and in IDLE when data_sram_en=1.
- Total latency for a zero-wait bus (addr_ok and data_ok one cycle apart): IDLE→REQ→WAIT→DONE, 3 stall cycles.
- Read encoding: bus_wr=0, bus_size=2, bus_wstrb=0, bus_addr low 2 bits forced to 00.
- Write encoding: bus_wr=1, bus_wstrb=wen, bus_addr unmodified.
  - bus_size=0 for one strobe bit set, 1 for 0011/1100, 2 for 1111.
  - Any other non-zero wen pattern: bus_size=2, strobes passed through unchanged.
- bus_data_ok while in IDLE/REQ without an outstanding request is ignored.
- bus_addr_ok outside REQ is ignored.
- data_sram_rdata changes only on a read's data_ok.
- Reset mid-transaction: state returns to IDLE immediately. Any later data_ok from the abandoned request is dropped in IDLE. No recovery of bus ordering is attempted.

Optional Feature:
- Macro DATA_BRIDGE_WBUF_EN.
- Defined:
  - Adds a one-entry posted write buffer.
  - A store in IDLE with the buffer empty is copied into the buffer; stallreq=0 that cycle; the store completes to the core in 0 stall cycles.
  - The buffer drains over the bus with the same REQ/WAIT handshake, in parallel with the pipeline.
  - A new access (load or store) arriving while the buffer is occupied stalls until the drain reaches data_ok; no forwarding from the buffer.
  - Buffer state is cleared on reset.
- Undefined: stores behave like loads (full blocking handshake). No buffer logic is present.

Test Plan:
- Load, zero-wait bus: en=1, wen=0000, addr=0x1000_0006; addr_ok in REQ, data_ok=1 with rdata=0xDEAD_BEEF next cycle → bus_addr=0x1000_0004, bus_size=2; stallreq high 3 cycles; rdata=0xDEAD_BEEF in DONE and held afterwards.
- Byte store: wen=0100, addr=0x2000_0002, wdata=0x00AB_0000 → bus_wr=1, bus_size=0, bus_wstrb=0100, bus_addr=0x2000_0002; data_sram_rdata unchanged.
- Slow bus: addr_ok delayed 4 cycles, data_ok 3 cycles later → bus_req held high with stable fields for 4 cycles; stallreq high until DONE; exactly one DONE cycle.
- Same-cycle addr_ok and data_ok in REQ (rdata=0x1234_5678) → direct REQ→DONE; rdata=0x1234_5678.
- Back-to-back: load then store with en held through DONE → no duplicate bus request for the first access; the second access is captured in the following IDLE cycle.
- Reset asserted in WAIT, then a stray data_ok after release → outputs at reset values; stray data_ok ignored; next load completes normally.
